// File: rtl/am_demod_pkg.sv
// Shared definitions for the AM demodulator envelope-smoothing blocks:
// default widths, the averaging controller state encoding and a clog2 helper.
package am_demod_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int MAX_LOG2_N_DEF = 6;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/avg_ring_buf.sv
// Sample-history storage for the boxcar average: one synchronous write port,
// one asynchronous read port, no reset (contents are rewritten by CLEAR).
module avg_ring_buf
  import am_demod_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1 << MAX_LOG2_N_DEF,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;

  // Read sees the pre-write contents when addresses collide.
  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/am_avg_ctrl.sv
// Exact boxcar moving average over the last 2^log2n envelope samples, with
// buffer clear, warm-up fill and run-time window reconfiguration.
module am_avg_ctrl
  import am_demod_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_LOG2_N = MAX_LOG2_N_DEF,
  parameter int SUM_W      = DATA_W + MAX_LOG2_N
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic [2:0]        i_cfg_log2n,
  input  logic              i_cfg_load,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_busy,
  output logic [2:0]        o_log2n
);

  localparam int         AW        = MAX_LOG2_N;
  localparam int         DEPTH     = 1 << MAX_LOG2_N;
  localparam logic [2:0] LOG2N_MAX = 3'(MAX_LOG2_N);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              o_data_valid_q, o_data_valid_d;
  logic              o_busy_q, o_busy_d;
  logic [2:0]        log2n_q, log2n_d;

  logic              buf_we;
  logic [AW-1:0]     buf_waddr;
  logic [DATA_W-1:0] buf_wdata, buf_rdata;

  logic [AW:0]       n_m1;
  logic [AW-1:0]     last_idx;
  logic [SUM_W:0]    sum_ext, mean;
  logic              unused;

  avg_ring_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ring (
    .i_clk   (i_clk),
    .i_we    (buf_we),
    .i_waddr (buf_waddr),
    .i_wdata (buf_wdata),
    .i_raddr (wr_ptr_q),
    .o_rdata (buf_rdata)
  );

  assign n_m1     = ((AW+1)'(1) << log2n_q) - (AW+1)'(1);
  assign last_idx = n_m1[AW-1:0];
  // Cleared slots guarantee old <= what sum already holds, so this never underflows.
  assign sum_ext  = {1'b0, sum_q} + (SUM_W+1)'(i_data) - (SUM_W+1)'(buf_rdata);
  assign mean     = sum_ext >> log2n_q;
  assign unused   = ^{sum_ext[SUM_W], mean[SUM_W:DATA_W], n_m1[AW]};

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    wr_ptr_d       = wr_ptr_q;
    fill_cnt_d     = fill_cnt_q;
    sum_d          = sum_q;
    o_data_d       = o_data_q;
    o_data_valid_d = 1'b0;
    o_busy_d       = o_busy_q;
    log2n_d        = log2n_q;
    buf_we         = 1'b0;
    buf_waddr      = wr_ptr_q;
    buf_wdata      = i_data;

    if (i_cfg_load) begin
      log2n_d   = (i_cfg_log2n > LOG2N_MAX) ? LOG2N_MAX : i_cfg_log2n;
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
      o_busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          buf_we    = 1'b1;
          buf_waddr = clr_cnt_q;
          buf_wdata = '0;
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_d    = ST_FILL;
            sum_d      = '0;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
          end
        end
        ST_FILL, ST_RUN: begin
          if (i_data_valid) begin
            buf_we   = 1'b1;
            sum_d    = sum_ext[SUM_W-1:0];
            o_data_d = mean[DATA_W-1:0];
            wr_ptr_d = (wr_ptr_q == last_idx) ? '0 : wr_ptr_q + AW'(1);
            if (state_q == ST_RUN) begin
              o_data_valid_d = 1'b1;
            end else if (fill_cnt_q == last_idx) begin
              o_data_valid_d = 1'b1;
              o_busy_d       = 1'b0;
              state_d        = ST_RUN;
            end else begin
              fill_cnt_d = fill_cnt_q + AW'(1);
            end
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_CLEAR;
      clr_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      fill_cnt_q     <= '0;
      sum_q          <= '0;
      o_data_q       <= '0;
      o_data_valid_q <= 1'b0;
      o_busy_q       <= 1'b1;
      log2n_q        <= LOG2N_MAX;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_cnt_q     <= fill_cnt_d;
      sum_q          <= sum_d;
      o_data_q       <= o_data_d;
      o_data_valid_q <= o_data_valid_d;
      o_busy_q       <= o_busy_d;
      log2n_q        <= log2n_d;
    end
  end

  assign o_data       = o_data_q;
  assign o_data_valid = o_data_valid_q;
  assign o_busy       = o_busy_q;
  assign o_log2n      = log2n_q;

endmodule
